// File: rtl/btn_conditioner.sv
// Purpose: synchronise, debounce and edge-strobe the cipher panel push-buttons (bit 0 left, 1 right, 2 set).
// Latency: a clean raw edge reaches btn_clean and its strobe DEBOUNCE_CYC + 2 cycles later.
// Backpressure: none; btn_raw is sampled every cycle and the strobes are fire-and-forget.
// Optional build macro AUTOREPEAT_EN adds held-button auto-repeat on bits 0 and 1.
module btn_conditioner #(
  parameter int N_BTN        = 3,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int REPEAT_DLY   = 25000000,
  parameter int REPEAT_PER   = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             btn_busy
);

  // One shared counter width covers both the debounce and the repeat intervals.
  localparam int MAX_RPT = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int MAX_CYC = (DEBOUNCE_CYC > MAX_RPT) ? DEBOUNCE_CYC : MAX_RPT;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A one-cycle filter would let single-sample glitches through.
  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYC must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE_UP = 2'd0,
    CHK_DN  = 2'd1,
    HELD    = 2'd2,
    CHK_UP  = 2'd3
  } state_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] chk_nxt;
  state_t           state [N_BTN];
  logic [CNT_W-1:0] cnt   [N_BTN];

`ifdef AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PER - 1);

  // rep_on marks that the first (long) repeat interval has already elapsed.
  logic [CNT_W-1:0] rep_cnt [N_BTN];
  logic [N_BTN-1:0] rep_on;
`endif

  // Two-flop synchroniser; idles high so an unpressed panel looks released out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Per-button debounce FSM with registered clean level and press/release strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= IDLE_UP;
        cnt[i]   <= '0;
`ifdef AUTOREPEAT_EN
        rep_cnt[i] <= '0;
`endif
      end
`ifdef AUTOREPEAT_EN
      rep_on      <= '0;
`endif
      btn_clean   <= '1;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        btn_press[i]   <= 1'b0;
        btn_release[i] <= 1'b0;
        case (state[i])
          IDLE_UP: begin
            if (!sync2[i]) begin
              state[i] <= CHK_DN;
              cnt[i]   <= CNT_ONE;
            end
          end
          CHK_DN: begin
            if (sync2[i]) begin
              // Bounced back before the window closed: drop it silently.
              state[i] <= IDLE_UP;
              cnt[i]   <= '0;
            end else if (cnt[i] == DB_LAST) begin
              state[i]     <= HELD;
              cnt[i]       <= '0;
              btn_clean[i] <= 1'b0;
              btn_press[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          HELD: begin
            if (sync2[i]) begin
              state[i] <= CHK_UP;
              cnt[i]   <= CNT_ONE;
`ifdef AUTOREPEAT_EN
              rep_cnt[i] <= '0;
              rep_on[i]  <= 1'b0;
`endif
            end else begin
`ifdef AUTOREPEAT_EN
              // Only the cursor buttons repeat; a repeated "set" would relaunch encryption.
              if (i < 2) begin
                if (rep_cnt[i] == (rep_on[i] ? RPT_NEXT : RPT_FIRST)) begin
                  btn_press[i] <= 1'b1;
                  rep_cnt[i]   <= '0;
                  rep_on[i]    <= 1'b1;
                end else begin
                  rep_cnt[i] <= rep_cnt[i] + CNT_ONE;
                end
              end
`endif
            end
          end
          CHK_UP: begin
            if (!sync2[i]) begin
              state[i] <= HELD;
              cnt[i]   <= '0;
            end else if (cnt[i] == DB_LAST) begin
              state[i]       <= IDLE_UP;
              cnt[i]         <= '0;
              btn_clean[i]   <= 1'b1;
              btn_release[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          default: begin
            state[i] <= IDLE_UP;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Next-cycle "in a checking state" per button, so btn_busy lines up with the FSM state.
  always_comb begin
    chk_nxt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      case (state[i])
        IDLE_UP: chk_nxt[i] = !sync2[i];
        CHK_DN:  chk_nxt[i] = !sync2[i] && (cnt[i] != DB_LAST);
        HELD:    chk_nxt[i] = sync2[i];
        CHK_UP:  chk_nxt[i] = sync2[i] && (cnt[i] != DB_LAST);
        default: chk_nxt[i] = 1'b0;
      endcase
    end
  end

  // Registered busy flag: any button currently inside a debounce window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_busy <= 1'b0;
    end else begin
      btn_busy <= |chk_nxt;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised and directed bench for btn_conditioner against a run-length reference model.
// Model: a button's accepted level flips once the raw pin (seen two samples late) has
// differed from it for DEBOUNCE_CYC consecutive samples; repeats count cycles spent held.
module tb_btn_conditioner;

  localparam int NB = 3;
  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RP = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] btn_raw = 3'b111;
  logic [NB-1:0] btn_clean;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          btn_busy;

  btn_conditioner #(
    .N_BTN       (NB),
    .DEBOUNCE_CYC(DB),
    .REPEAT_DLY  (RD),
    .REPEAT_PER  (RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_clean  (btn_clean),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_busy   (btn_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [NB-1:0] hist [$];
  logic [NB-1:0] m_clean;
  logic [NB-1:0] m_press;
  logic [NB-1:0] m_release;
  logic          m_busy;
  int            run      [NB];
  int            held_cyc [NB];
  bit            was_held [NB];

  task automatic model_reset();
    hist.delete();
    m_clean   = '1;
    m_press   = '0;
    m_release = '0;
    m_busy    = 1'b0;
    for (int b = 0; b < NB; b++) begin
      run[b]      = 0;
      held_cyc[b] = 0;
      was_held[b] = 0;
    end
  endtask

  // Advance the model by one clock edge, given the raw pins present at that edge.
  task automatic model_edge(input logic [NB-1:0] raw);
    logic [NB-1:0] seen;
    bit held;
    hist.push_back(raw);
    if (hist.size() > 3) void'(hist.pop_front());
    seen   = (hist.size() >= 3) ? hist[hist.size()-3] : '1;
    m_busy = 1'b0;
    for (int b = 0; b < NB; b++) begin
      m_press[b]   = 1'b0;
      m_release[b] = 1'b0;
      if (seen[b] != m_clean[b]) begin
        run[b]++;
        if (run[b] == DB) begin
          m_clean[b] = seen[b];
          if (seen[b] == 1'b0) m_press[b] = 1'b1;
          else                 m_release[b] = 1'b1;
          run[b] = 0;
        end
      end else begin
        run[b] = 0;
      end
      held = (m_clean[b] == 1'b0) && (run[b] == 0);
`ifdef AUTOREPEAT_EN
      if (held && was_held[b] && b < 2) begin
        held_cyc[b]++;
        if (held_cyc[b] == RD || (held_cyc[b] > RD && (held_cyc[b] - RD) % RP == 0))
          m_press[b] = 1'b1;
      end else begin
        held_cyc[b] = 0;
      end
`endif
      was_held[b] = held;
      if (run[b] > 0) m_busy = 1'b1;
    end
  endtask

  // One clock: sample 1 ns after the edge, update the model, compare every output.
  task automatic step();
    @(posedge clk);
    #1;
    if (reset) model_edge(btn_raw);
    check("clean",   32'(btn_clean),   32'(m_clean));
    check("press",   32'(btn_press),   32'(m_press));
    check("release", 32'(btn_release), 32'(m_release));
    check("busy",    32'(btn_busy),    32'(m_busy));
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    model_reset();
    repeat (cycles) step();
    reset = 1'b1;
  endtask

  int  lat;
  bit  saw_busy;
  int  hold_left [NB];

  initial begin
    model_reset();
    // Reset and idle: nothing pressed for 100 cycles.
    do_reset(3);
    repeat (100) step();

    // Single press on bit 0: strobe DB+2 cycles after the edge.
    btn_raw[0] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (btn_press[0] && lat < 0) lat = k;
    end
    check("press0_lat", 32'(lat), 32'(DB + 2));
    repeat (10) step();
    btn_raw[0] = 1'b1;
    repeat (20) step();

    // Bounce on bit 1 every 3 cycles: never accepted, busy while bouncing.
    saw_busy = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) btn_raw[1] = ~btn_raw[1];
      step();
      if (btn_busy) saw_busy = 1;
    end
    btn_raw[1] = 1'b1;
    repeat (20) step();
    check("bounce_busy", 32'(saw_busy), 32'd1);

    // Bits 0 and 2 together, released 50 cycles later.
    btn_raw = 3'b010;
    repeat (50) step();
    btn_raw = 3'b111;
    repeat (20) step();

    // Reset in the middle of a bit-2 debounce, button still held afterwards.
    btn_raw[2] = 1'b0;
    repeat (5) step();
    do_reset(4);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (btn_press[2] && lat < 0) lat = k;
    end
    check("press2_after_rst", 32'(lat), 32'(DB + 2));
    btn_raw[2] = 1'b1;
    repeat (20) step();

    // Long hold on bits 0 and 2 (exercises auto-repeat when built in).
    btn_raw = 3'b010;
    repeat (60) step();
    btn_raw = 3'b111;
    repeat (20) step();

    // Random pin activity with a mix of bounces and accepted holds, rare resets.
    for (int b = 0; b < NB; b++) hold_left[b] = $urandom_range(1, 2 * DB + 4);
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < NB; b++) begin
        hold_left[b]--;
        if (hold_left[b] <= 0) begin
          btn_raw[b]   = ~btn_raw[b];
          hold_left[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(RD, 3 * RD)
                                                     : $urandom_range(1, 2 * DB + 4);
        end
      end
      if ($urandom_range(0, 599) == 0) do_reset(2);
      else step();
    end
    btn_raw = 3'b111;
    repeat (30) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
